ita14_rx: RTL

ITA14_RX -- requirements
Module: ita14_rx

---
 rtl/ita14_rx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ita14_rx.sv
// 14-segment display scanner receiver: captures 12-digit frames into a committed buffer.
// Optional ITA14_RX_MATCH_EN adds a 'match' output flagging the "   NADA     " frame.
module ita14_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sel,
  input  logic [13:0] segm,
  input  logic [3:0]  rd_idx,
  output logic [5:0]  rd_char,
  output logic        frame_done,
  output logic        frame_err,
  output logic        char_err,
`ifdef ITA14_RX_MATCH_EN
  output logic        match,
`endif
  output logic        locked
);

  typedef enum logic {HUNT, RECV} state_t;

  state_t      state;
  logic [3:0]  exp;
  logic [11:0] s_sel;
  logic [13:0] s_segm;
  logic [5:0]  shadow    [11];
  logic [5:0]  committed [12];

  logic [5:0]  code;
  logic        bad;
  logic [3:0]  sel_idx;
  logic        sel_one;

  always_comb begin
    code = 6'h3F;
    bad  = 1'b1;
    case (s_segm)
      14'b00000000000000: begin code = 6'h00; bad = 1'b0; end
      14'b11101111000000: begin code = 6'h01; bad = 1'b0; end
      14'b11110000010010: begin code = 6'h04; bad = 1'b0; end
      14'b01101100100100: begin code = 6'h0E; bad = 1'b0; end
      default:            begin code = 6'h3F; bad = 1'b1; end
    endcase
  end

  always_comb begin
    sel_idx = 4'd0;
    for (int i = 0; i < 12; i++)
      if (s_sel[i]) sel_idx = 4'(i);
  end

  assign sel_one = $onehot(s_sel);
  assign rd_char = (rd_idx < 4'd12) ? committed[rd_idx] : 6'h00;

`ifdef ITA14_RX_MATCH_EN
  localparam logic [5:0] NADA [12] = '{6'h00, 6'h00, 6'h00, 6'h0E, 6'h01, 6'h04,
                                       6'h01, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
  logic match_next;

  // Evaluated against the frame being committed, not the old buffer.
  always_comb begin
    match_next = (code == NADA[11]);
    for (int i = 0; i < 11; i++)
      if (shadow[i] != NADA[i]) match_next = 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      exp        <= 4'd0;
      s_sel      <= 12'h000;
      s_segm     <= 14'h0000;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      char_err   <= 1'b0;
      locked     <= 1'b0;
`ifdef ITA14_RX_MATCH_EN
      match      <= 1'b0;
`endif
      for (int i = 0; i < 11; i++) shadow[i] <= 6'h00;
      for (int i = 0; i < 12; i++) committed[i] <= 6'h00;
    end else begin
      s_sel      <= sel;
      s_segm     <= segm;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      char_err   <= 1'b0;
      case (state)
        HUNT: begin
          if (s_sel == 12'h001) begin
            shadow[0] <= code;
            char_err  <= bad;
            exp       <= 4'd1;
            state     <= RECV;
          end
        end
        RECV: begin
          if (s_sel == 12'h000 || (sel_one && sel_idx == exp - 4'd1)) begin
            state <= RECV;
          end else if (sel_one && sel_idx == exp) begin
            char_err <= bad;
            if (exp == 4'd11) begin
              for (int i = 0; i < 11; i++) committed[i] <= shadow[i];
              committed[11] <= code;
              frame_done    <= 1'b1;
              locked        <= 1'b1;
`ifdef ITA14_RX_MATCH_EN
              match         <= match_next;
`endif
              exp           <= 4'd0;
              state         <= HUNT;
            end else begin
              shadow[exp] <= code;
              exp         <= exp + 4'd1;
            end
          end else begin
            frame_err <= 1'b1;
            locked    <= 1'b0;
            // A digit-0 select that breaks the sequence also starts the next frame.
            if (s_sel == 12'h001) begin
              shadow[0] <= code;
              char_err  <= bad;
              exp       <= 4'd1;
              state     <= RECV;
            end else begin
              exp   <= 4'd0;
              state <= HUNT;
            end
          end
        end
        default: begin
          exp   <= 4'd0;
          state <= HUNT;
        end
      endcase
    end
  end

endmodule
